// File: rtl/axis_join_arbiter_4_pkg.sv
// Shared types and constants for the 4-port AXI4-Stream join arbiter and its
// round-robin select.
package axis_join_arbiter_4_pkg;

   localparam int AXIS_DATA_WIDTH = 64;
   localparam int AXIS_S_COUNT    = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PKT  = 1'b1
   } join_state_t;

   // Width of a port index; never narrower than one bit.
   function automatic int id_width(input int s_count);
      return (s_count > 1) ? $clog2(s_count) : 1;
   endfunction

endpackage

// File: rtl/axis_join_arbiter_4_if.sv
// Handshake bundle of the join: S_COUNT input streams, one tagged output
// stream, the per-input enables and the busy flag.
interface axis_join_arbiter_4_if
   import axis_join_arbiter_4_pkg::*;
#(
   parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
   parameter int S_COUNT    = AXIS_S_COUNT
);
   localparam int ID_W = id_width(S_COUNT);

   logic [S_COUNT-1:0]            ien;
   logic [S_COUNT-1:0]            s_axis_tready;
   logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata;
   logic [S_COUNT-1:0]            s_axis_tlast;
   logic [S_COUNT-1:0]            s_axis_tvalid;
   logic                          m_axis_tready;
   logic [DATA_WIDTH-1:0]         m_axis_tdata;
   logic                          m_axis_tlast;
   logic                          m_axis_tvalid;
   logic [ID_W-1:0]               m_axis_tid;
   logic                          busy;

   // The join itself.
   modport slave (
      input  ien, s_axis_tdata, s_axis_tlast, s_axis_tvalid, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tvalid,
             m_axis_tid, busy
   );

   // The surrounding datapath: sources, sink and control.
   modport master (
      output ien, s_axis_tdata, s_axis_tlast, s_axis_tvalid, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tvalid,
             m_axis_tid, busy
   );

endinterface

// File: rtl/axis_join_arbiter_4_rr_arbiter.sv
// Combinational round-robin select: first requester after last_grant,
// searching upward with wrap-around.
module axis_rr_arbiter
   import axis_join_arbiter_4_pkg::*;
#(
   parameter int S_COUNT = AXIS_S_COUNT,
   parameter int ID_W    = id_width(S_COUNT)
) (
   input  logic [S_COUNT-1:0] req,
   input  logic [ID_W-1:0]    last_grant,
   output logic [ID_W-1:0]    grant,
   output logic               valid
);

   always_comb begin
      int          idx;
      logic [ID_W-1:0] pick;
      // NOTE: every output and temporary gets a value before the loop, so no
      // path through this block can leave a latch behind.
      grant = '0;
      valid = 1'b0;
      idx   = 0;
      pick  = '0;
      for (int i = 1; i <= S_COUNT; i++) begin
         idx  = (int'(last_grant) + i) % S_COUNT;
         pick = ID_W'(idx);
         if (!valid && req[pick]) begin
            valid = 1'b1;
            grant = pick;
         end
      end
   end

endmodule

// File: rtl/axis_join_arbiter_4.sv
// Four-input AXI4-Stream join: round-robin whole-packet grants, registered
// output tagged with the source port index.
module axis_join_arbiter_4
   import axis_join_arbiter_4_pkg::*;
#(
   parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
   parameter int S_COUNT    = AXIS_S_COUNT
) (
   input  logic                  clk,
   input  logic                  rst,
   axis_join_arbiter_4_if.slave  bus
);

   localparam int ID_W = id_width(S_COUNT);

   join_state_t           state;
   logic [ID_W-1:0]       grant;
   logic [ID_W-1:0]       last_grant;
   logic [ID_W-1:0]       arb_grant;
   logic                  arb_valid;
   logic [S_COUNT-1:0]    req;
   logic                  out_ready;
   logic                  beat_acc;
   logic [DATA_WIDTH-1:0] s_data [S_COUNT];

   for (genvar g = 0; g < S_COUNT; g++) begin : g_unpack
      assign s_data[g] = bus.s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // Enables only matter at arbitration time; a running packet ignores them.
   assign req       = bus.s_axis_tvalid & bus.ien;
   assign out_ready = bus.m_axis_tready | ~bus.m_axis_tvalid;
   assign beat_acc  = (state == ST_PKT) & bus.s_axis_tvalid[grant] & out_ready;
   assign bus.busy  = (state == ST_PKT);

   axis_rr_arbiter #(
      .S_COUNT (S_COUNT),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .req        (req),
      .last_grant (last_grant),
      .grant      (arb_grant),
      .valid      (arb_valid)
   );

   always_comb begin
      bus.s_axis_tready = '0;
      if (state == ST_PKT) begin
         bus.s_axis_tready[grant] = out_ready;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= ST_IDLE;
         grant             <= '0;
         last_grant        <= ID_W'(S_COUNT - 1);
         bus.m_axis_tvalid <= 1'b0;
         bus.m_axis_tdata  <= '0;
         bus.m_axis_tlast  <= 1'b0;
         bus.m_axis_tid    <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register here
         // samples the pre-edge value of grant/state regardless of order.
         if (out_ready) begin
            bus.m_axis_tvalid <= beat_acc;
            if (beat_acc) begin
               bus.m_axis_tdata <= s_data[grant];
               bus.m_axis_tlast <= bus.s_axis_tlast[grant];
               bus.m_axis_tid   <= grant;
            end
         end

         case (state)
            ST_IDLE: begin
               if (arb_valid) begin
                  grant <= arb_grant;
                  state <= ST_PKT;
               end
            end
            ST_PKT: begin
               if (beat_acc && bus.s_axis_tlast[grant]) begin
                  last_grant <= grant;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
